le_cmp_arbiter: RTL and testbench
=================================

LE_CMP_ARBITER -- requirements
Module: le_cmp_arbiter

Interface
REQ-001 Parameter WIDTH, default 24: operand MSB index; operands are WIDTH+1 bits in FloPoCo format (2-bit exception, sign, exponent, fraction).
REQ-002 Parameter LAT, default 3, minimum 1: cycles from cmp_a/cmp_b presentation to the matching cmp_le.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  4  per-requester compare request.
REQ-006 req_ready  out  4  per-requester grant; transfer when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-007 req_a  in  4*(WIDTH+1)  operand A; requester i owns slice i.
REQ-008 req_b  in  4*(WIDTH+1)  operand B; requester i owns slice i.
REQ-009 flush  in  1  synchronous abort of all in-flight work.
REQ-010 cmp_a  out  WIDTH+1  operand A to the shared less-or-equal comparator.
REQ-011 cmp_b  out  WIDTH+1  operand B to the shared comparator.
REQ-012 cmp_le  in  1  comparator result, meaning A <= B, valid LAT cycles after its operands.
REQ-013 rsp_valid  out  4  one-hot response strobe, one cycle wide.
REQ-014 rsp_le  out  1  result for the requester flagged in rsp_valid.
REQ-015 busy  out  1  high while any request is outstanding or in the pipeline.

Function
REQ-016 The block SHALL hold at most one outstanding request per requester; eligible[i] = req_valid[i] and not outstanding[i].
REQ-017 Arbitration SHALL be round-robin over eligible requesters, starting at the pointer; at most one req_ready bit SHALL be high per cycle, derived combinationally.
REQ-018 On transfer from requester g, the pointer SHALL become (g+1) mod 4; with no transfer, the pointer SHALL be unchanged.
REQ-019 A transfer at edge t SHALL register the operands, so cmp_a/cmp_b carry them during cycle t+1; cmp_a/cmp_b SHALL hold their last values when no transfer occurs.
REQ-020 A tag pipeline of LAT+1 stages (valid bit plus 2-bit id) SHALL track each issue; the tag reaches the tail in the cycle cmp_le is valid for it.
REQ-021 rsp_valid and rsp_le SHALL be registered from the tail tag and cmp_le; response in cycle t+2+LAT, so total latency is LAT+2 cycles and responses are in issue order.
REQ-022 outstanding[i] SHALL set on transfer and clear at the edge that raises rsp_valid[i]; req_ready[i] MAY assert in that same cycle.
REQ-023 Back-to-back issue SHALL be supported: one transfer per cycle sustained, with no bubbles between different requesters.
REQ-024 flush high at an edge SHALL clear all tag valids and outstanding bits and suppress any response for that edge; req_ready SHALL be all-zero while flush is high; the pointer SHALL be kept.
REQ-025 A response scheduled for the cycle after a flush SHALL NOT appear, even if it was issued LAT+1 cycles earlier.
REQ-026 busy SHALL equal OR(outstanding) OR OR(tag valids).
REQ-027 req_a/req_b of non-granted requesters SHALL NOT affect any output.

Reset
REQ-028 While rst is low: pointer=0, outstanding=0, tag pipeline invalid, cmp_a=cmp_b=0, rsp_valid=0, rsp_le=0, busy=0, req_ready=0.
REQ-029 Deasserting rst SHALL allow grants from the first rising edge after release; a reset mid-operation SHALL discard all in-flight requests with no response.

Verification
REQ-030 Bench model: comparator returns (A <= B) delayed by LAT=3; test WIDTH=24.
REQ-031 Single request: requester 2 sends A=1.0, B=2.0 at edge 0 -> cmp_a=1.0 in cycle 1; rsp_valid=4'b0100 and rsp_le=1 in cycle 5; busy low from cycle 6.
REQ-032 All four valid at edge 0 with pointer 0 -> grants to 0,1,2,3 at edges 0..3; responses 0001,0010,0100,1000 in cycles 5..8.
REQ-033 Requester 0 held valid continuously -> second grant in the cycle rsp_valid[0] is high (cycle 5), never earlier; requesters 1-3 are served in between when valid.
REQ-034 Issue requests from requesters 1 and 3 at edges 0 and 1, assert flush at edge 3 -> no rsp_valid in cycles 4..8; busy=0 from cycle 4; the next request issues normally.
REQ-035 Assert rst low in cycle 3 with two requests in flight -> all outputs zero immediately; no responses after release; pointer restarts at 0.
REQ-036 Equal operands (A=B=-0.5) and A=+inf with B=1.0 -> rsp_le=1 and rsp_le=0 respectively, each routed to the issuing requester.

Source files
------------

// File: rtl/le_cmp_arbiter.sv
// le_cmp_arbiter
// Shares a single pipelined less-or-equal comparator between four
// requesters. Requests are granted round-robin, the granted operands are
// registered onto the comparator inputs, and a tag pipeline tracks each
// issue so the comparator result is routed back to its requester.
// Each requester may have at most one request in flight.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-low
//   req_valid  per-requester compare request
//   req_ready  per-requester grant (combinational, at most one bit high)
//   req_a      operand A, requester i owns slice i (WIDTH+1 bits each)
//   req_b      operand B, requester i owns slice i
//   flush      synchronous abort of all in-flight work
//   cmp_a      operand A to the shared comparator
//   cmp_b      operand B to the shared comparator
//   cmp_le     comparator result (A <= B), valid LAT cycles after operands
//   rsp_valid  one-hot response strobe, one cycle wide
//   rsp_le     result for the requester flagged in rsp_valid
//   busy       high while any request is outstanding or in the pipeline
module le_cmp_arbiter #(
    parameter int WIDTH = 24,
    parameter int LAT   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             req_valid,
    output logic [3:0]             req_ready,
    input  logic [4*(WIDTH+1)-1:0] req_a,
    input  logic [4*(WIDTH+1)-1:0] req_b,
    input  logic                   flush,
    output logic [WIDTH:0]         cmp_a,
    output logic [WIDTH:0]         cmp_b,
    input  logic                   cmp_le,
    output logic [3:0]             rsp_valid,
    output logic                   rsp_le,
    output logic                   busy
);

    localparam int OW = WIDTH + 1;

    logic [1:0]        ptr;
    logic [3:0]        outstanding;
    logic [3:0]        eligible;
    logic              grant_any;
    logic [1:0]        grant_id;
    logic [1:0]        idx;
    logic [3:0]        grant_oh;
    logic              xfer;
    logic [WIDTH:0]    sel_a;
    logic [WIDTH:0]    sel_b;
    logic [LAT:0]      tag_vld_p;
    logic [LAT:0][1:0] tag_id_p;
    logic              tail_vld;
    logic [3:0]        rsp_set;

    // Round-robin search starting at ptr. The loop runs from the farthest
    // candidate to the nearest so the nearest eligible requester wins.
    always_comb begin
        eligible  = req_valid & ~outstanding;
        grant_any = 1'b0;
        grant_id  = ptr;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        grant_oh = '0;
        // No grants while flushing or held in reset.
        if (grant_any && !flush && rst) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant_oh;
    assign xfer      = |grant_oh;

    // Only the granted slice reaches the operand registers, so the other
    // requesters' operands cannot influence any output.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_id == 2'(i)) begin
                sel_a = req_a[i*OW +: OW];
                sel_b = req_b[i*OW +: OW];
            end
        end
    end

    // The tail tag is aligned with cmp_le; a flush kills its response.
    always_comb begin
        tail_vld = tag_vld_p[LAT] & ~flush;
        rsp_set  = '0;
        if (tail_vld) begin
            rsp_set[tag_id_p[LAT]] = 1'b1;
        end
    end

    // Stage p0: issue -- operand registers, tag entry, pointer advance.
    // Stages p1..pLAT: tag shift in step with the comparator latency.
    // Response stage: register strobe and result from the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            outstanding <= '0;
            tag_vld_p   <= '0;
            rsp_valid   <= '0;
            rsp_le      <= 1'b0;
            cmp_a       <= '0;
            cmp_b       <= '0;
        end else begin
            if (xfer) begin
                ptr   <= grant_id + 2'd1;
                cmp_a <= sel_a;
                cmp_b <= sel_b;
            end
            if (flush) begin
                tag_vld_p   <= '0;
                outstanding <= '0;
            end else begin
                tag_vld_p   <= {tag_vld_p[LAT-1:0], xfer};
                // Clearing on the response edge lets the same requester be
                // granted again in the cycle its response is visible.
                outstanding <= (outstanding & ~rsp_set) | grant_oh;
            end
            rsp_valid <= rsp_set;
            rsp_le    <= tail_vld & cmp_le;
        end
    end

    // Tag ids are qualified by tag_vld_p, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_id_p <= {tag_id_p[LAT-1:0], grant_id};
    end

    assign busy = (|outstanding) | (|tag_vld_p);

endmodule

// File: tb/tb_le_cmp_arbiter.sv
module tb_le_cmp_arbiter;

    localparam int WIDTH = 24;
    localparam int LAT   = 3;
    localparam int OW    = WIDTH + 1;

    // FloPoCo encodings: exn[24:23], sign[22], exponent[21:14], fraction[13:0]
    localparam logic [WIDTH:0] ONE   = {2'b01, 1'b0, 8'd127, 14'd0};
    localparam logic [WIDTH:0] TWO   = {2'b01, 1'b0, 8'd128, 14'd0};
    localparam logic [WIDTH:0] MHALF = {2'b01, 1'b1, 8'd126, 14'd0};
    localparam logic [WIDTH:0] PINF  = {2'b10, 1'b0, 8'd0,   14'd0};

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [4*OW-1:0]   req_a;
    logic [4*OW-1:0]   req_b;
    logic              flush;
    logic [WIDTH:0]    cmp_a;
    logic [WIDTH:0]    cmp_b;
    logic              cmp_le;
    logic [3:0]        rsp_valid;
    logic              rsp_le;
    logic              busy;

    always #5 clk = ~clk;

    le_cmp_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_le    (cmp_le),
        .rsp_valid (rsp_valid),
        .rsp_le    (rsp_le),
        .busy      (busy)
    );

    // Comparator model: ordered key per FloPoCo value, result delayed LAT cycles.
    function automatic longint fkey(input logic [WIDTH:0] v);
        longint m;
        case (v[WIDTH:WIDTH-1])
            2'b00:   m = 0;
            2'b01:   m = longint'(v[WIDTH-3:0]) + 1;
            default: m = longint'(1) << (WIDTH - 1);
        endcase
        return v[WIDTH-2] ? -m : m;
    endfunction

    function automatic logic le_model(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        if (x[WIDTH:WIDTH-1] == 2'b11 || y[WIDTH:WIDTH-1] == 2'b11) return 1'b0;
        return fkey(x) <= fkey(y);
    endfunction

    logic [LAT-1:0] cmp_pipe = '0;
    always @(posedge clk) cmp_pipe <= {cmp_pipe[LAT-2:0], le_model(cmp_a, cmp_b)};
    assign cmp_le = cmp_pipe[LAT-1];

    int ec = 0;
    always @(posedge clk) ec <= ec + 1;

    typedef struct {
        int   id;
        logic le;
        int   cyc;
    } exp_t;

    exp_t q[$];
    logic exp_le[4];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, ec);
        end
    endtask

    // Monitor and scoreboard: pops and compares when a response is due, flags
    // strays, drops entries killed by flush/reset, and pushes on each transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (q.size() > 0 && q[0].cyc == ec) begin
                e = q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                chk("rsp_le", 32'(rsp_le), 32'(e.le));
            end else if (rsp_valid != 4'b0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none (cycle %0d)", rsp_valid, ec);
            end
            if (flush) begin
                while (q.size() > 0 && q[q.size()-1].cyc > ec) void'(q.pop_back());
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) q.push_back('{i, exp_le[i], ec + LAT + 2});
            end
        end else begin
            q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH:0] a, input logic [WIDTH:0] b, input logic e);
        req_a[i*OW +: OW] = a;
        req_b[i*OW +: OW] = b;
        exp_le[i] = e;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 60), 32'd1);
    endtask

    logic [3:0] vt3[6] = '{4'b0001, 4'b1011, 4'b1001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] rt3[6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        for (int i = 0; i < 4; i++) exp_le[i] = 1'b0;

        // Reset state, with requests pending
        tick();
        tick();
        req_valid = 4'hf;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cmp_a", 32'(cmp_a), 32'd0);
        chk("rst_cmp_b", 32'(cmp_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_le", 32'(rsp_le), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        tick();
        rst = 1'b1;

        // Single request from requester 2: 1.0 <= 2.0
        set_op(2, ONE, TWO, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("single_cmp_a", 32'(cmp_a), 32'(ONE));
        chk("single_cmp_b", 32'(cmp_b), 32'(TWO));
        chk("single_busy_c1", 32'(busy), 32'd1);
        tick(); tick(); tick();
        chk("single_busy_c4", 32'(busy), 32'd1);
        tick(); tick();
        chk("single_busy_c6", 32'(busy), 32'd0);
        chk("single_drained", 32'(q.size()), 32'd0);

        // All four valid, pointer 0; also equal operands and +inf routing
        rst = 1'b0;
        #1;
        rst = 1'b1;
        set_op(0, ONE, TWO, 1'b1);
        set_op(1, TWO, ONE, 1'b0);
        set_op(2, MHALF, MHALF, 1'b1);
        set_op(3, PINF, ONE, 1'b0);
        req_valid = 4'hf;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1) << g);
            tick();
            req_valid[g] = 1'b0;
        end
        drain();

        // Requester 0 held valid: regrant only in its response cycle
        set_op(0, ONE, TWO, 1'b1);
        set_op(1, TWO, ONE, 1'b0);
        set_op(3, MHALF, MHALF, 1'b1);
        for (int c = 0; c < 6; c++) begin
            req_valid = vt3[c];
            #1;
            chk("hold0_ready", 32'(req_ready), 32'(rt3[c]));
            if (c == 5) chk("hold0_rsp_same_cycle", 32'(rsp_valid), 32'b0001);
            tick();
        end
        req_valid = '0;
        drain();

        // Flush with requesters 1 and 3 in flight
        set_op(1, ONE, TWO, 1'b1);
        set_op(3, TWO, ONE, 1'b0);
        req_valid = 4'b1010;
        #1;
        chk("flush_grant1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("flush_grant3", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        flush = 1'b1;
        set_op(2, MHALF, ONE, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("flush_ready_zero", 32'(req_ready), 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        for (int c = 4; c <= 8; c++) begin
            chk("flush_busy", 32'(busy), 32'd0);
            chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        req_valid = 4'b0100;
        #1;
        chk("flush_next_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        drain();

        // Reset mid-operation with two requests in flight
        set_op(1, TWO, ONE, 1'b0);
        set_op(2, ONE, TWO, 1'b1);
        req_valid = 4'b0110;
        #1;
        chk("mrst_grant1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0100;
        #1;
        chk("mrst_grant2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b0;
        set_op(1, MHALF, ONE, 1'b1);
        set_op(3, ONE, MHALF, 1'b0);
        req_valid = 4'b1010;
        #1;
        chk("mrst_cmp_a", 32'(cmp_a), 32'd0);
        chk("mrst_cmp_b", 32'(cmp_b), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_ptr_restart", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        #1;
        chk("mrst_next_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        drain();
        for (int c = 0; c < 4; c++) tick();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
